// File: rtl/emu_clk_pkg.sv
// Shared types and helpers for the emulator clock/gate generator.
package emu_clk_pkg;

  // Reset-hold / running states of the generator.
  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } emu_state_e;

  // Width of the hold counter: enough to hold the value rst_hold itself.
  function automatic int hold_cnt_w(input int rst_hold);
    return (rst_hold < 1) ? 1 : $clog2(rst_hold + 1);
  endfunction

endpackage

// File: rtl/emu_clk_gate_cell.sv
// One glitch-free gated copy of emu_clk, registered on emu_clk_2x.
module emu_clk_gate_cell (
  input  logic emu_clk_2x,
  input  logic emu_rst,
  input  logic phase,
  input  logic eff_en,
  output logic gated_clk
);

  // Rise when emu_clk rises and the enable is set; always fall with emu_clk.
  always_ff @(posedge emu_clk_2x or posedge emu_rst) begin
    if (emu_rst) gated_clk <= 1'b0;
    else         gated_clk <= ~phase & eff_en;
  end

endmodule

// File: rtl/emu_clk_gate_gen.sv
// Divide-by-2 emu_clk, per-domain gated clocks, held reset and cycle counter.
module emu_clk_gate_gen
  import emu_clk_pkg::*;
#(
  parameter int N_GATED  = 2,
  parameter int RST_HOLD = 4,
  parameter int CNT_W    = 32
) (
  input  logic               emu_clk_2x,
  input  logic               emu_rst,
  input  logic [N_GATED-1:0] gate_en,
  output logic               emu_clk,
  output logic [N_GATED-1:0] gated_clk,
  output logic               emu_rst_out,
  output logic [CNT_W-1:0]   emu_cycle,
  output logic               running
);

  localparam int            HW       = hold_cnt_w(RST_HOLD);
  localparam logic [HW-1:0] HOLD_MAX = HW'(RST_HOLD);

  logic               phase;
  emu_state_e         state, state_nxt;
  logic [HW-1:0]      hold_cnt;
  logic [CNT_W-1:0]   cyc;
  logic [N_GATED-1:0] eff_en;

  // phase is emu_clk itself; phase==0 on a posedge means emu_clk is rising.
  always_ff @(posedge emu_clk_2x or posedge emu_rst) begin
    if (emu_rst) phase <= 1'b0;
    else         phase <= ~phase;
  end

  // State register.
  always_ff @(posedge emu_clk_2x or posedge emu_rst) begin
    if (emu_rst) state <= HOLD;
    else         state <= state_nxt;
  end

  // Leave HOLD only on an emu_clk falling edge, so reset release is mid-period.
  always_comb begin
    state_nxt   = state;
    emu_rst_out = 1'b1;
    running     = 1'b0;
    case (state)
      HOLD: if (phase && (hold_cnt == HOLD_MAX)) state_nxt = RUN;
      RUN: begin
        emu_rst_out = 1'b0;
        running     = 1'b1;
      end
      default: state_nxt = HOLD;
    endcase
  end

  // Count emu_clk rises spent in HOLD, saturating at the hold length.
  always_ff @(posedge emu_clk_2x or posedge emu_rst) begin
    if (emu_rst)
      hold_cnt <= '0;
    else if ((state == HOLD) && !phase && (hold_cnt != HOLD_MAX))
      hold_cnt <= hold_cnt + 1'b1;
  end

  // Free-running emulation cycle count of emu_clk rises in RUN; wraps silently.
  always_ff @(posedge emu_clk_2x or posedge emu_rst) begin
    if (emu_rst)                      cyc <= '0;
    else if ((state == RUN) && !phase) cyc <= cyc + 1'b1;
  end

  // Force every domain clocked during HOLD so models see reset-time edges.
  assign eff_en = (state == RUN) ? gate_en : {N_GATED{1'b1}};

  for (genvar g = 0; g < N_GATED; g++) begin : g_cell
    emu_clk_gate_cell u_cell (
      .emu_clk_2x (emu_clk_2x),
      .emu_rst    (emu_rst),
      .phase      (phase),
      .eff_en     (eff_en[g]),
      .gated_clk  (gated_clk[g])
    );
  end

  assign emu_clk   = phase;
  assign emu_cycle = cyc;

endmodule
